// File: rtl/accum_cpu_gen2.sv
// Accumulator CPU: multi-cycle FETCH/DECODE/INDIRECT/EXECUTE machine with
// single-level indirect addressing and a single-port external memory.
module accum_cpu_gen2 #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              clr,
   output logic              read,
   output logic              write,
   output logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] memoryOut,
   output logic [DATA_W-1:0] memoryIn,
   output logic [DATA_W-1:0] ac,
   output logic              carry,
   output logic              zero,
   output logic              halted
);

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      INDIRECT,
      EXECUTE,
      HALT
   } state_t;

   typedef enum logic [2:0] {
      OP_HALT  = 3'b000,
      OP_ADD   = 3'b001,
      OP_XNOR  = 3'b010,
      OP_AND   = 3'b011,
      OP_LOAD  = 3'b100,
      OP_STORE = 3'b101,
      OP_JMP   = 3'b110,
      OP_JZ    = 3'b111
   } op_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] ea;
   logic [DATA_W-1:0] ir;
   logic              ind;
   op_t               op;
   logic [ADDR_W-1:0] ir_addr;
   logic [DATA_W:0]   sum;

   assign ind      = ir[DATA_W-1];
   assign op       = op_t'(ir[DATA_W-2 -: 3]);
   assign ir_addr  = ir[ADDR_W-1:0];
   assign sum      = {1'b0, ac} + {1'b0, memoryOut};
   assign memoryIn = ac;
   assign zero     = (ac == '0);
   assign halted   = (state == HALT);

   always_ff @(posedge clk) begin
      if (!clr) begin
         state <= FETCH;
         pc    <= '0;
         ac    <= '0;
         ir    <= '0;
         ea    <= '0;
         carry <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            FETCH: begin
               ir <= memoryOut;
               pc <= pc + 1'b1;
            end
            DECODE: begin
               if (op != OP_HALT && !ind) ea <= ir_addr;
            end
            INDIRECT: ea <= memoryOut[ADDR_W-1:0];
            EXECUTE: begin
               case (op)
                  OP_ADD:  {carry, ac} <= sum;
                  OP_XNOR: ac <= ~(ac ^ memoryOut);
                  OP_AND:  ac <= ac & memoryOut;
                  OP_LOAD: ac <= memoryOut;
                  OP_JMP:  pc <= ea;
                  OP_JZ:   if (zero) pc <= ea;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   // Address idles at PC whenever no memory access is made.
   always_comb begin
      state_next = state;
      read       = 1'b0;
      write      = 1'b0;
      address    = pc;
      case (state)
         FETCH: begin
            read       = 1'b1;
            state_next = DECODE;
         end
         DECODE: begin
            if (op == OP_HALT)  state_next = HALT;
            else if (ind)       state_next = INDIRECT;
            else                state_next = EXECUTE;
         end
         INDIRECT: begin
            address    = ir_addr;
            read       = 1'b1;
            state_next = EXECUTE;
         end
         EXECUTE: begin
            state_next = FETCH;
            case (op)
               OP_ADD, OP_XNOR, OP_AND, OP_LOAD: begin
                  address = ea;
                  read    = 1'b1;
               end
               OP_STORE: begin
                  address = ea;
                  write   = 1'b1;
               end
               default: ;
            endcase
         end
         HALT: state_next = HALT;
         default: state_next = FETCH;
      endcase
      // A reset asserted mid-cycle must kill any pending store.
      if (!clr) begin
         read  = 1'b0;
         write = 1'b0;
      end
   end

endmodule

// File: tb/tb_accum_cpu_gen2.sv
// Directed bench for accum_cpu_gen2: default 8/4 instance plus a 16/8 instance,
// each attached to a bench-owned memory model.
module tb_accum_cpu_gen2;

   logic clk;

   logic        clr_a;
   logic        read_a;
   logic        write_a;
   logic [3:0]  address_a;
   logic [7:0]  mem_out_a;
   logic [7:0]  mem_in_a;
   logic [7:0]  ac_a;
   logic        carry_a;
   logic        zero_a;
   logic        halted_a;
   logic [7:0]  mem_a [16];
   logic        clear_a;
   logic        load_en_a;
   logic [3:0]  load_addr_a;
   logic [7:0]  load_data_a;
   int          write_count_a;

   logic        clr_b;
   logic        read_b;
   logic        write_b;
   logic [7:0]  address_b;
   logic [15:0] mem_out_b;
   logic [15:0] mem_in_b;
   logic [15:0] ac_b;
   logic        carry_b;
   logic        zero_b;
   logic        halted_b;
   logic [15:0] mem_b [256];
   logic        clear_b;
   logic        load_en_b;
   logic [7:0]  load_addr_b;
   logic [15:0] load_data_b;

   int checks;
   int errors;

   accum_cpu_gen2 dut_a (
      .clk(clk), .clr(clr_a), .read(read_a), .write(write_a),
      .address(address_a), .memoryOut(mem_out_a), .memoryIn(mem_in_a),
      .ac(ac_a), .carry(carry_a), .zero(zero_a), .halted(halted_a)
   );

   accum_cpu_gen2 #(.DATA_W(16), .ADDR_W(8)) dut_b (
      .clk(clk), .clr(clr_b), .read(read_b), .write(write_b),
      .address(address_b), .memoryOut(mem_out_b), .memoryIn(mem_in_b),
      .ac(ac_b), .carry(carry_b), .zero(zero_b), .halted(halted_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_out_a = mem_a[address_a];
   assign mem_out_b = mem_b[address_b];

   always @(posedge clk) begin
      if (clear_a) begin
         for (int i = 0; i < 16; i++) mem_a[i] <= '0;
         write_count_a <= 0;
      end else if (load_en_a) begin
         mem_a[load_addr_a] <= load_data_a;
      end else if (write_a) begin
         mem_a[address_a] <= mem_in_a;
         write_count_a    <= write_count_a + 1;
      end
   end

   always @(posedge clk) begin
      if (clear_b) begin
         for (int i = 0; i < 256; i++) mem_b[i] <= '0;
      end else if (load_en_b) begin
         mem_b[load_addr_b] <= load_data_b;
      end else if (write_b) begin
         mem_b[address_b] <= mem_in_b;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
      load_en_a   = 1'b1;
      load_addr_a = addr;
      load_data_a = data;
      tick(1);
      load_en_a   = 1'b0;
   endtask

   task automatic applyStimulusWide(input logic [7:0] addr, input logic [15:0] data);
      load_en_b   = 1'b1;
      load_addr_b = addr;
      load_data_b = data;
      tick(1);
      load_en_b   = 1'b0;
   endtask

   task automatic resetAndClearA();
      clr_a   = 1'b0;
      clear_a = 1'b1;
      tick(1);
      clear_a = 1'b0;
      tick(1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clr_a = 1'b0; clr_b = 1'b0;
      clear_a = 1'b0; load_en_a = 1'b0; load_addr_a = '0; load_data_a = '0;
      clear_b = 1'b0; load_en_b = 1'b0; load_addr_b = '0; load_data_b = '0;
      tick(1);

      // Reset state
      resetAndClearA();
      checkOutput("rst_ac", ac_a, 8'h00);
      checkOutput("rst_carry", carry_a, 1'b0);
      checkOutput("rst_zero", zero_a, 1'b1);
      checkOutput("rst_halted", halted_a, 1'b0);
      checkOutput("rst_read", read_a, 1'b0);
      checkOutput("rst_write", write_a, 1'b0);

      // LOAD / indirect XNOR / STORE / HALT
      applyStimulus(4'h0, 8'h45);
      applyStimulus(4'h1, 8'hA7);
      applyStimulus(4'h2, 8'h54);
      applyStimulus(4'h5, 8'h05);
      applyStimulus(4'h6, 8'h54);
      applyStimulus(4'h7, 8'h06);
      clr_a = 1'b1;
      #1;
      checkOutput("first_fetch_read", read_a, 1'b1);
      checkOutput("first_fetch_addr", address_a, 4'h0);
      tick(3);
      checkOutput("load_ac", ac_a, 8'h05);
      tick(4);
      checkOutput("xnor_ind_ac", ac_a, 8'hAE);
      tick(3);
      checkOutput("store_mem4", mem_a[4], 8'hAE);
      tick(2);
      checkOutput("halt_flag", halted_a, 1'b1);
      tick(3);
      checkOutput("halt_hold", halted_a, 1'b1);
      checkOutput("halt_ac", ac_a, 8'hAE);
      checkOutput("halt_addr_pc", address_a, 4'h4);
      checkOutput("halt_read", read_a, 1'b0);
      checkOutput("halt_write", write_a, 1'b0);
      checkOutput("store_once", write_count_a, 1);

      // ADD with carry out and carry clear
      resetAndClearA();
      applyStimulus(4'h0, 8'h48);
      applyStimulus(4'h1, 8'h19);
      applyStimulus(4'h2, 8'h1A);
      applyStimulus(4'h8, 8'hF0);
      applyStimulus(4'h9, 8'h20);
      applyStimulus(4'hA, 8'h01);
      clr_a = 1'b1;
      tick(3);
      checkOutput("add_load_ac", ac_a, 8'hF0);
      tick(3);
      checkOutput("add1_ac", ac_a, 8'h10);
      checkOutput("add1_carry", carry_a, 1'b1);
      tick(3);
      checkOutput("add2_ac", ac_a, 8'h11);
      checkOutput("add2_carry", carry_a, 1'b0);
      tick(2);
      checkOutput("add_halted", halted_a, 1'b1);

      // JZ taken
      resetAndClearA();
      applyStimulus(4'h0, 8'h4F);
      applyStimulus(4'h1, 8'h75);
      clr_a = 1'b1;
      tick(8);
      checkOutput("jz_taken_halted", halted_a, 1'b1);
      checkOutput("jz_taken_pc", address_a, 4'h6);
      checkOutput("jz_taken_zero", zero_a, 1'b1);

      // JZ not taken
      resetAndClearA();
      applyStimulus(4'h0, 8'h4F);
      applyStimulus(4'h1, 8'h75);
      applyStimulus(4'hF, 8'h01);
      clr_a = 1'b1;
      tick(8);
      checkOutput("jz_fall_halted", halted_a, 1'b1);
      checkOutput("jz_fall_pc", address_a, 4'h3);
      checkOutput("jz_fall_ac", ac_a, 8'h01);

      // PC wrap 15 -> 0
      resetAndClearA();
      applyStimulus(4'h0, 8'h6F);
      applyStimulus(4'hF, 8'h4E);
      clr_a = 1'b1;
      tick(6);
      checkOutput("wrap_fetch_addr", address_a, 4'h0);
      checkOutput("wrap_fetch_read", read_a, 1'b1);
      checkOutput("wrap_ac", ac_a, 8'h00);
      tick(3);
      checkOutput("wrap_rejmp_addr", address_a, 4'hF);

      // Reset during STORE execute
      resetAndClearA();
      applyStimulus(4'h0, 8'h45);
      applyStimulus(4'h1, 8'h54);
      applyStimulus(4'h4, 8'h77);
      applyStimulus(4'h5, 8'h33);
      clr_a = 1'b1;
      tick(3);
      checkOutput("ms_load_ac", ac_a, 8'h33);
      tick(2);
      checkOutput("ms_store_write", write_a, 1'b1);
      checkOutput("ms_store_addr", address_a, 4'h4);
      checkOutput("ms_store_read", read_a, 1'b0);
      clr_a = 1'b0;
      #1;
      checkOutput("ms_clr_write", write_a, 1'b0);
      checkOutput("ms_clr_read", read_a, 1'b0);
      tick(1);
      checkOutput("ms_mem4", mem_a[4], 8'h77);
      checkOutput("ms_ac", ac_a, 8'h00);
      checkOutput("ms_writes", write_count_a, 0);
      clr_a = 1'b1;
      #1;
      checkOutput("ms_fetch_addr", address_a, 4'h0);
      checkOutput("ms_fetch_read", read_a, 1'b1);
      clr_a = 1'b0;

      // 16/8 instance: 0xFFFF + 1 and PC wrap 255 -> 0
      clear_b = 1'b1;
      tick(1);
      clear_b = 1'b0;
      applyStimulusWide(8'h00, 16'h60FD);
      applyStimulusWide(8'hFD, 16'h4010);
      applyStimulusWide(8'hFE, 16'h1011);
      applyStimulusWide(8'h10, 16'hFFFF);
      applyStimulusWide(8'h11, 16'h0001);
      clr_b = 1'b1;
      tick(6);
      checkOutput("w_load_ac", ac_b, 16'hFFFF);
      tick(3);
      checkOutput("w_add_ac", ac_b, 16'h0000);
      checkOutput("w_add_carry", carry_b, 1'b1);
      checkOutput("w_add_zero", zero_b, 1'b1);
      tick(2);
      checkOutput("w_halted", halted_b, 1'b1);
      checkOutput("w_pc_wrap", address_b, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/accum_cpu_gen2.md
ACCUM_CPU_GEN2 -- requirements
Module: accum_cpu_gen2

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data/instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 4, memory address width; legal only when DATA_W >= ADDR_W+4.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port read  output  1  high while CPU samples memoryOut this cycle.
REQ-006 SHALL have port write  output  1  high for exactly the cycle memory captures memoryIn at the next rising edge.
REQ-007 SHALL have port address  output  ADDR_W  memory address.
REQ-008 SHALL have port memoryOut  input  DATA_W  combinational read data, memory[address].
REQ-009 SHALL have port memoryIn  output  DATA_W  store data, always equal to AC.
REQ-010 SHALL have ports ac (output, DATA_W, accumulator), carry (output, 1, carry flag), zero (output, 1, AC==0, combinational), halted (output, 1, high in HALT state).

Function
REQ-011 Instruction word SHALL decode as: bit DATA_W-1 = I (indirect), bits DATA_W-2..DATA_W-4 = op, bits ADDR_W-1..0 = addr; remaining bits ignored.
REQ-012 Opcodes SHALL be: 000 HALT, 001 ADD, 010 XNOR, 011 AND, 100 LOAD, 101 STORE, 110 JMP, 111 JZ.
REQ-013 FSM states SHALL be FETCH, DECODE, INDIRECT, EXECUTE, HALT.
REQ-014 FETCH: address=PC, read=1; IR<=memoryOut; PC<=PC+1 modulo 2^ADDR_W (15 wraps to 0 at default); next DECODE.
REQ-015 DECODE: read=0, write=0; op HALT -> HALT (I ignored); else I=1 -> INDIRECT; else EA<=addr, next EXECUTE.
REQ-016 INDIRECT: address=IR addr, read=1; EA<=memoryOut[ADDR_W-1:0]; next EXECUTE (single level only).
REQ-017 EXECUTE, ADD: address=EA, read=1; {carry,AC}<=AC+memoryOut, DATA_W+1-bit result.
REQ-018 EXECUTE, XNOR/AND/LOAD: address=EA, read=1; AC<=~(AC^M), AC&M, M respectively; carry unchanged.
REQ-019 EXECUTE, STORE: address=EA, write=1, read=0; AC, carry unchanged.
REQ-020 EXECUTE, JMP: PC<=EA; JZ: PC<=EA only if zero=1, else PC unchanged; no memory access.
REQ-021 EXECUTE SHALL always return to FETCH; direct instruction = 3 cycles, indirect = 4, HALT detected 2 cycles after its FETCH begins.
REQ-022 HALT state SHALL hold all registers, read=0, write=0, halted=1 until reset.
REQ-023 address SHALL be PC in DECODE and HALT (don't-care data, read=0).
REQ-024 write SHALL never be high outside EXECUTE of STORE; read and write SHALL never be high together.

Reset
REQ-025 On rising edge with clr=0: PC=0, AC=0, IR=0, EA=0, carry=0, state=FETCH; halted=0.
REQ-026 While clr=0, read=0 and write=0 combinationally, so reset mid-STORE SHALL suppress the write.
REQ-027 First FETCH SHALL occur on the first rising edge after clr returns high.

Verification
REQ-028 Defaults; M0=0x45 LOAD 5, M1=0xA7 XNOR [M7], M2=0x54 STORE 4, M3=0x00 HALT, M5=0x05, M6=0x54, M7=0x06 -> M4=0xAE, ac=0xAE, halted=1 after 15 cycles, M4 written once.
REQ-029 ADD: M0=0x48 LOAD 8, M1=0x19 ADD 9, M2=0x1A ADD 10, M3=0x00, M8=0xF0, M9=0x20, MA=0x01 -> after M1 ac=0x10, carry=1; after M2 ac=0x11, carry=0.
REQ-030 JZ: M0=0x4F LOAD MF=0x00, M1=0x75 JZ 5, M5=0x00 HALT -> halted with PC=6; repeat with MF=0x01 -> falls through to M2.
REQ-031 Wrap: M0=0x6F JMP 15, MF=0x4E LOAD 14, ME=0x00 -> PC wraps 15->0, FETCH at address 0 after MF, ac=0x00 re-executes JMP.
REQ-032 Reset mid-STORE: clr=0 during STORE EXECUTE -> write=0 that cycle, target word unchanged, next FETCH address=0, ac=0.
REQ-033 DATA_W=16, ADDR_W=8: LOAD/ADD 0xFFFF+0x0001 -> ac=0x0000, carry=1, zero=1; PC wraps 255->0.
